list_fetch: RTL and testbench
=============================

// Module: list_fetch
// PURPOSE
//  Linked-list walker directly upstream of list_cache. Given a head pointer, it
//  reads one FS-word node per memory burst and presents each node as one FS-word
//  packet (OUT[FS][DW]) with a valid/ready handshake. Packet-parity bit
//  OUT[0][0] toggles per packet so list_cache detects a new node.
//  It follows the next pointer (word NEXT_IDX) until nil (0).
// PARAMETERS
//  DW        32     data word width (bits)
//  AW        32     byte address width
//  FS        4      words per node/packet; must match list_cache fetch size
//  NEXT_IDX  2      node word index holding the next-node byte pointer
//  CW        16     node counter width; walk aborts with error at 2**CW-1 nodes
// PORTS
//  CLK           in   1        clock
//  RESET         in   1        synchronous, active-high reset
//  start_valid   in   1        walk request
//  start_ready   out  1        high only in IDLE
//  start_ptr     in   AW       head node byte address (0 = empty list)
//  abort         in   1        cancel current walk
//  mem_req_valid out  1        burst read request
//  mem_req_ready in   1        memory accepts request
//  mem_req_addr  out  AW       node base address, low $clog2(FS*DW/8) bits forced 0
//  mem_rsp_valid in   1        one data beat, in order, FS beats per request
//  mem_rsp_data  in   DW       beat data
//  OUT           out  FS*DW    packet; OUT[i] = node word i, OUT[0][0] = parity
//  o_valid       out  1        packet valid
//  i_ready       in   1        list_cache o_ready
//  busy          out  1        state != IDLE
//  done          out  1        1-cycle pulse: walk finished or aborted
//  error         out  1        sticky until next accepted start: node limit hit
//  node_count    out  CW       nodes delivered in current or last walk
// BEHAVIOUR
//  Reset: state IDLE; start_ready=1; mem_req_valid=0; o_valid=0; OUT=0;
//   done=0; error=0; node_count=0. Parity register=1, so first packet carries 0.
//  FSM states: IDLE, REQ, RECV, PRESENT, DRAIN.
//   IDLE:    on start_valid, latch ptr, clear node_count and error.
//            ptr==0 -> done pulse next cycle, stay IDLE. Else -> REQ.
//   REQ:     mem_req_valid=1, addr=ptr. On mem_req_ready -> RECV, beat count=0.
//   RECV:    each mem_rsp_valid writes buffer word[beat]; word 0 bit0 is
//            replaced by ~parity. After beat FS-1 -> PRESENT with parity
//            toggled. o_valid rises the cycle after the last beat.
//   PRESENT: OUT/o_valid held stable until i_ready. On handshake: node_count+1,
//            ptr=word[NEXT_IDX]. If next==0 -> IDLE + done. If node_count reaches
//            2**CW-1 -> error=1, IDLE + done. Otherwise -> REQ the next cycle.
//   DRAIN:   entered when abort fires in RECV. Discard remaining beats of
//            the open burst, then IDLE + done.
//  abort in REQ with no request accepted, or in PRESENT: -> IDLE + done,
//   o_valid=0, no packet is delivered. abort in IDLE is ignored.
//   abort beats start_valid; start_valid is not sampled outside IDLE.
//  At most one burst is outstanding; there is no prefetch.
//  Node latency: request handshake to o_valid = FS beats + 1 cycle.
//  o_valid never drops without a handshake, except on abort or RESET.
//  mem_rsp_valid outside RECV/DRAIN is ignored. Memory shares RESET, so RESET
//   mid-walk returns to the reset state with no drain.
//  Parity continues across walks (never re-initialised except by RESET),
//   so list_cache always sees alternating bits.
// STRUCTURE
//  Package list_pkg: localparams FS, DW, NEXT_IDX, NIL_PTR=0; typedef
//   node_t = logic [FS-1:0][DW-1:0]; enum fetch_state_t. list_cache imports FS.
//  One sub-module: list_node_buf. It holds the FS-word assembly register,
//   beat counter, parity insert and NEXT_IDX extraction. FSM stays in top.
// TESTING
//  1 3-node list at 0x100->0x200->0x300->0, mem 2-cycle latency, i_ready=1
//    -> 3 packets, OUT[0][0]=0,1,0; node_count=3; done once; error=0.
//  2 start_ptr=0 -> no mem_req_valid, done pulse 1 cycle after start, no o_valid.
//  3 Packet 1 with i_ready held low 10 cycles -> OUT stable, o_valid high,
//    no new mem_req until handshake.
//  4 abort after beat 1 of a 4-beat burst -> remaining 2 beats dropped,
//    done pulse, o_valid stays 0, next walk's first parity continues sequence.
//  5 CW=3, 8-node circular list (next points back to head) -> 7 packets,
//    error=1, done, IDLE.
//  6 start_ptr=0x10C (misaligned) -> mem_req_addr=0x100; RESET asserted
//    in RECV -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/list_pkg.sv
// list_pkg: shared constants and types for the linked-list fetch path.
//   FS        words per node / packet (list_cache imports this)
//   DW        data word width in bits
//   NEXT_IDX  node word holding the next-node byte pointer
//   NIL_PTR   list terminator
//   node_t    one assembled node / packet, word i at [i]
//   fetch_state_t  walker FSM states
package list_pkg;

    localparam int unsigned FS         = 4;
    localparam int unsigned DW         = 32;
    localparam int unsigned NEXT_IDX   = 2;
    localparam int unsigned NIL_PTR    = 0;
    localparam int unsigned NODE_BYTES = FS * DW / 8;

    typedef logic [FS-1:0][DW-1:0] node_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRecv,
        StPresent,
        StDrain
    } fetch_state_t;

endpackage

// File: rtl/list_node_buf.sv
// list_node_buf: assembles one FS-word node from in-order memory beats.
//   CLK, RESET   clock, synchronous active-high reset
//   beat_clear   zero the beat counter (request accepted)
//   beat_en      a beat of the open burst arrived (counted even when discarded)
//   wr_en        store the current beat into the node register
//   commit       node completed and will be presented: flip parity
//   rsp_data     beat data
//   beat_last    current beat is the final one of the burst
//   node         assembled node; word 0 bit 0 carries the packet parity
//   next_ptr     next-node byte pointer taken from word NEXT_IDX
module list_node_buf
    import list_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          beat_clear,
    input  logic          beat_en,
    input  logic          wr_en,
    input  logic          commit,
    input  logic [DW-1:0] rsp_data,
    output logic          beat_last,
    output node_t         node,
    output logic [AW-1:0] next_ptr
);

    localparam int unsigned BW = (FS > 1) ? $clog2(FS) : 1;

    logic [BW-1:0] beat_q;
    logic          parity_q;
    node_t         node_q;
    logic [DW-1:0] wr_word;

    assign beat_last = (beat_q == BW'(FS - 1));

    // Word 0 bit 0 is overwritten with the packet parity so list_cache sees a fresh node.
    always_comb begin
        wr_word = rsp_data;
        if (beat_q == '0) begin
            wr_word[0] = ~parity_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            beat_q   <= '0;
            parity_q <= 1'b1;
            node_q   <= '0;
        end else begin
            if (beat_clear) begin
                beat_q <= '0;
            end else if (beat_en) begin
                beat_q <= beat_q + BW'(1);
            end
            if (wr_en) begin
                node_q[beat_q] <= wr_word;
            end
            if (commit) begin
                parity_q <= ~parity_q;
            end
        end
    end

    assign node     = node_q;
    assign next_ptr = AW'(node_q[NEXT_IDX]);

endmodule

// File: rtl/list_fetch.sv
// list_fetch: walks a linked list from a head pointer, one burst read per node,
// presenting each node as an FS-word packet to list_cache.
//   CLK, RESET                   clock, synchronous active-high reset
//   start_valid/ready, start_ptr walk request; ready only when idle; ptr 0 = empty
//   abort                        cancel the current walk (ignored when idle)
//   mem_req_valid/ready/addr     burst read request, node-aligned address
//   mem_rsp_valid/data           FS in-order beats per request
//   OUT, o_valid, i_ready        packet handshake towards list_cache
//   busy                         walk in progress
//   done                         one-cycle pulse when a walk ends or aborts
//   error                        node limit hit; sticky until next accepted start
//   node_count                   nodes delivered in current or last walk
module list_fetch
    import list_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [AW-1:0] start_ptr,
    input  logic          abort,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_data,
    output node_t         OUT,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] node_count
);

    localparam int unsigned   OFF_BITS   = $clog2(NODE_BYTES);
    localparam logic [AW-1:0] ADDR_MASK  = ~AW'((1 << OFF_BITS) - 1);
    localparam logic [CW-1:0] NODE_LIMIT = '1;

    fetch_state_t  state_q;
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] next_ptr;
    logic [CW-1:0] count_inc;
    logic          beat_last;
    logic          req_fire;
    logic          recv_beat;
    logic          drain_beat;

    assign req_fire     = (state_q == StReq) && mem_req_ready;
    assign recv_beat    = (state_q == StRecv) && mem_rsp_valid;
    assign drain_beat   = (state_q == StDrain) && mem_rsp_valid;
    assign count_inc    = node_count + CW'(1);
    assign mem_req_addr = ptr_q;

    list_node_buf #(
        .AW (AW)
    ) u_node_buf (
        .CLK        (CLK),
        .RESET      (RESET),
        .beat_clear (req_fire),
        .beat_en    (recv_beat || drain_beat),
        .wr_en      (recv_beat),
        // An abort on the final beat drops the node, so parity must not advance.
        .commit     (recv_beat && beat_last && !abort),
        .rsp_data   (mem_rsp_data),
        .beat_last  (beat_last),
        .node       (OUT),
        .next_ptr   (next_ptr)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            start_ready   <= 1'b1;
            mem_req_valid <= 1'b0;
            o_valid       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            node_count    <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        ptr_q      <= start_ptr & ADDR_MASK;
                        node_count <= '0;
                        error      <= 1'b0;
                        if (start_ptr == AW'(NIL_PTR)) begin
                            done <= 1'b1;
                        end else begin
                            state_q       <= StReq;
                            start_ready   <= 1'b0;
                            busy          <= 1'b1;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (mem_req_ready) begin
                        // Once accepted the burst is open; an abort must drain it.
                        mem_req_valid <= 1'b0;
                        state_q       <= abort ? StDrain : StRecv;
                    end else if (abort) begin
                        state_q       <= StIdle;
                        mem_req_valid <= 1'b0;
                        start_ready   <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                    end
                end
                StRecv: begin
                    if (recv_beat && beat_last) begin
                        if (abort) begin
                            state_q     <= StIdle;
                            start_ready <= 1'b1;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            state_q <= StPresent;
                            o_valid <= 1'b1;
                        end
                    end else if (abort) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_beat && beat_last) begin
                        state_q     <= StIdle;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                StPresent: begin
                    if (abort) begin
                        state_q     <= StIdle;
                        o_valid     <= 1'b0;
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else if (i_ready) begin
                        o_valid    <= 1'b0;
                        node_count <= count_inc;
                        ptr_q      <= next_ptr & ADDR_MASK;
                        if (next_ptr == AW'(NIL_PTR)) begin
                            state_q     <= StIdle;
                            start_ready <= 1'b1;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else if (count_inc == NODE_LIMIT) begin
                            error       <= 1'b1;
                            state_q     <= StIdle;
                            start_ready <= 1'b1;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            state_q       <= StReq;
                            mem_req_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    mem_req_valid <= 1'b0;
                    o_valid       <= 1'b0;
                    start_ready   <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_list_fetch.sv
// tb_list_fetch: directed bench for list_fetch with a 2-cycle-latency burst memory model.
module tb_list_fetch;
    import list_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 3;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [AW-1:0] start_ptr = '0;
    logic          abort = 1'b0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    node_t         OUT;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          error;
    logic [CW-1:0] node_count;

    list_fetch #(
        .AW (AW),
        .CW (CW)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .start_ptr     (start_ptr),
        .abort         (abort),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .OUT           (OUT),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .node_count    (node_count)
    );

    always #5 CLK = ~CLK;

    // Memory: word-addressed store, 2 idle cycles after a request, then FS back-to-back beats.
    logic [31:0] mem [0:1023];
    logic [AW-1:0] pend_addr;
    int lat;
    int beats_left;

    always @(posedge CLK) begin
        if (RESET) begin
            lat           <= 0;
            beats_left    <= 0;
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= '0;
            pend_addr     <= '0;
        end else begin
            mem_rsp_valid <= 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                pend_addr  <= mem_req_addr;
                lat        <= 2;
                beats_left <= FS;
            end else if (beats_left != 0) begin
                if (lat != 0) begin
                    lat <= lat - 1;
                end else begin
                    mem_rsp_valid <= 1'b1;
                    mem_rsp_data  <= mem[(pend_addr >> 2) + FS - beats_left];
                    beats_left    <= beats_left - 1;
                end
            end
        end
    end

    // Monitor: event counters and a log of delivered packets.
    int done_cnt = 0;
    int req_cnt = 0;
    int rsp_cnt = 0;
    int ov_cnt = 0;
    int hs_cnt = 0;
    node_t out_log [0:63];

    always @(posedge CLK) begin
        if (done) done_cnt <= done_cnt + 1;
        if (mem_req_valid && mem_req_ready) req_cnt <= req_cnt + 1;
        if (mem_rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (o_valid) ov_cnt <= ov_cnt + 1;
        if (o_valid && i_ready) begin
            out_log[hs_cnt % 64] <= OUT;
            hs_cnt <= hs_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    logic exp_par = 1'b0;  // parity bit the next delivered packet must carry

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic build_node(input logic [31:0] addr, input logic [31:0] next);
        mem[(addr >> 2) + 0] = {addr[15:0], 16'h0001};
        mem[(addr >> 2) + 1] = 32'hA000_0000 | addr;
        mem[(addr >> 2) + 2] = next;
        mem[(addr >> 2) + 3] = 32'h5A5A_0000 | addr;
    endtask

    task automatic start_walk(input logic [31:0] p);
        @(negedge CLK);
        start_valid = 1'b1;
        start_ptr   = p;
        @(negedge CLK);
        start_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (done_cnt == base) begin
            n_fail++;
            $display("FAIL %s_done_wait: done pulses=%0d, required %0d", name, done_cnt - base, 1);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_checks++;
        if ({start_ready, mem_req_valid, o_valid, busy, done, error} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 100000",
                     {start_ready, mem_req_valid, o_valid, busy, done, error});
        end
        n_checks++;
        if (OUT !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got %h, required 0", OUT);
        end
        n_checks++;
        if (node_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d, required 0", node_count);
        end
    endtask

    task automatic test_list3();
        int d0 = done_cnt;
        int h0 = hs_cnt;
        logic [31:0] a;
        i_ready = 1'b1;
        start_walk(32'h100);
        wait_done(d0, 200, "list3");
        repeat (4) @(negedge CLK);
        n_checks++;
        if (hs_cnt - h0 != 3) begin
            n_fail++;
            $display("FAIL list3_packets: got %0d, required 3", hs_cnt - h0);
        end
        for (int k = 0; k < 3; k++) begin
            a = 32'h100 * (k + 1);
            n_checks++;
            if (out_log[(h0 + k) % 64][0] !== {a[15:0], 15'h0, exp_par}) begin
                n_fail++;
                $display("FAIL list3_word0[%0d]: got %h, required %h", k,
                         out_log[(h0 + k) % 64][0], {a[15:0], 15'h0, exp_par});
            end
            n_checks++;
            if (out_log[(h0 + k) % 64][NEXT_IDX] !== ((k == 2) ? 32'h0 : a + 32'h100)) begin
                n_fail++;
                $display("FAIL list3_next[%0d]: got %h, required %h", k,
                         out_log[(h0 + k) % 64][NEXT_IDX], (k == 2) ? 32'h0 : a + 32'h100);
            end
            exp_par = ~exp_par;
        end
        n_checks++;
        if (node_count !== 3'd3 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL list3_count: got count=%0d error=%b, required 3 0", node_count, error);
        end
        n_checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0 || start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL list3_end: got done=%0d busy=%b ready=%b, required 1 0 1",
                     done_cnt - d0, busy, start_ready);
        end
    endtask

    task automatic test_empty();
        int r0 = req_cnt;
        int v0 = ov_cnt;
        start_walk(32'h0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || node_count !== '0) begin
            n_fail++;
            $display("FAIL empty_pulse: got done=%b busy=%b count=%0d, required 1 0 0",
                     done, busy, node_count);
        end
        @(negedge CLK);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_pulse_width: got done=%b, required 0", done);
        end
        repeat (3) @(negedge CLK);
        n_checks++;
        if (req_cnt != r0 || ov_cnt != v0) begin
            n_fail++;
            $display("FAIL empty_activity: got reqs=%0d valids=%0d, required 0 0",
                     req_cnt - r0, ov_cnt - v0);
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt;
        int h0 = hs_cnt;
        int r0;
        int n = 0;
        i_ready = 1'b0;
        start_walk(32'h100);
        while (o_valid !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_wait: o_valid=%b, required 1", o_valid);
        end
        r0 = req_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            n_checks++;
            if (o_valid !== 1'b1 || OUT[0] !== {16'h0100, 15'h0, exp_par}
                || OUT[NEXT_IDX] !== 32'h200) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b w0=%h w2=%h, required 1 %h 00000200",
                         c, o_valid, OUT[0], OUT[NEXT_IDX], {16'h0100, 15'h0, exp_par});
            end
        end
        n_checks++;
        if (req_cnt != r0) begin
            n_fail++;
            $display("FAIL bp_no_req: got %0d requests, required 0", req_cnt - r0);
        end
        i_ready = 1'b1;
        wait_done(d0, 200, "bp");
        repeat (2) @(negedge CLK);
        n_checks++;
        if (hs_cnt - h0 != 3) begin
            n_fail++;
            $display("FAIL bp_packets: got %0d, required 3", hs_cnt - h0);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_log[(h0 + k) % 64][0][0] !== exp_par) begin
                n_fail++;
                $display("FAIL bp_parity[%0d]: got %b, required %b", k,
                         out_log[(h0 + k) % 64][0][0], exp_par);
            end
            exp_par = ~exp_par;
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        int h0 = hs_cnt;
        int v0 = ov_cnt;
        int s0 = rsp_cnt;
        int n = 0;
        i_ready = 1'b1;
        start_walk(32'h100);
        while (rsp_cnt - s0 < 2 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (rsp_cnt - s0 != 2) begin
            n_fail++;
            $display("FAIL abort_beat_wait: got %0d beats, required 2", rsp_cnt - s0);
        end
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        wait_done(d0, 20, "abort");
        repeat (3) @(negedge CLK);
        n_checks++;
        if (hs_cnt != h0 || ov_cnt != v0) begin
            n_fail++;
            $display("FAIL abort_no_packet: got packets=%0d valids=%0d, required 0 0",
                     hs_cnt - h0, ov_cnt - v0);
        end
        n_checks++;
        if (rsp_cnt - s0 != 4 || done_cnt - d0 != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_drain: got beats=%0d done=%0d busy=%b, required 4 1 0",
                     rsp_cnt - s0, done_cnt - d0, busy);
        end
        // Follow-up single-node walk must continue the parity sequence.
        d0 = done_cnt;
        h0 = hs_cnt;
        start_walk(32'h300);
        wait_done(d0, 50, "abort_next");
        @(negedge CLK);
        n_checks++;
        if (hs_cnt - h0 != 1 || out_log[h0 % 64][0][0] !== exp_par) begin
            n_fail++;
            $display("FAIL abort_next_parity: got packets=%0d parity=%b, required 1 %b",
                     hs_cnt - h0, out_log[h0 % 64][0][0], exp_par);
        end
        exp_par = ~exp_par;
    endtask

    task automatic test_limit();
        int d0 = done_cnt;
        int h0 = hs_cnt;
        logic [31:0] a;
        for (int k = 0; k < 8; k++) begin
            a = 32'h400 + 32'h10 * k;
            build_node(a, 32'h400 + 32'h10 * ((k + 1) % 8));
        end
        i_ready = 1'b1;
        start_walk(32'h400);
        wait_done(d0, 400, "limit");
        repeat (3) @(negedge CLK);
        n_checks++;
        if (hs_cnt - h0 != 7) begin
            n_fail++;
            $display("FAIL limit_packets: got %0d, required 7", hs_cnt - h0);
        end
        n_checks++;
        if (error !== 1'b1 || node_count !== 3'd7) begin
            n_fail++;
            $display("FAIL limit_error: got error=%b count=%0d, required 1 7", error, node_count);
        end
        n_checks++;
        if (busy !== 1'b0 || start_ready !== 1'b1 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL limit_idle: got busy=%b ready=%b done=%0d, required 0 1 1",
                     busy, start_ready, done_cnt - d0);
        end
        for (int k = 0; k < 7; k++) begin
            n_checks++;
            if (out_log[(h0 + k) % 64][0][0] !== exp_par) begin
                n_fail++;
                $display("FAIL limit_parity[%0d]: got %b, required %b", k,
                         out_log[(h0 + k) % 64][0][0], exp_par);
            end
            exp_par = ~exp_par;
        end
        // error stays until the next accepted start, which clears it.
        start_walk(32'h0);
        n_checks++;
        if (error !== 1'b0 || node_count !== '0) begin
            n_fail++;
            $display("FAIL limit_clear: got error=%b count=%0d, required 0 0", error, node_count);
        end
    endtask

    task automatic test_misaligned_reset();
        int s0 = rsp_cnt;
        int h0;
        int d0;
        int n = 0;
        start_walk(32'h10C);
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL misalign_addr: got valid=%b addr=%h, required 1 00000100",
                     mem_req_valid, mem_req_addr);
        end
        while (rsp_cnt == s0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (rsp_cnt == s0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_recv: got beats=%0d busy=%b, required >0 1", rsp_cnt - s0, busy);
        end
        RESET = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({start_ready, mem_req_valid, o_valid, busy, done, error} !== 6'b100000
            || OUT !== '0 || node_count !== '0) begin
            n_fail++;
            $display("FAIL midwalk_reset: got flags=%b out=%h count=%0d, required 100000 0 0",
                     {start_ready, mem_req_valid, o_valid, busy, done, error}, OUT, node_count);
        end
        RESET = 1'b0;
        exp_par = 1'b0;
        d0 = done_cnt;
        h0 = hs_cnt;
        start_walk(32'h300);
        wait_done(d0, 50, "post_reset");
        @(negedge CLK);
        n_checks++;
        if (hs_cnt - h0 != 1 || out_log[h0 % 64][0] !== {16'h0300, 15'h0, exp_par}) begin
            n_fail++;
            $display("FAIL post_reset_packet: got packets=%0d w0=%h, required 1 %h",
                     hs_cnt - h0, out_log[h0 % 64][0], {16'h0300, 15'h0, exp_par});
        end
    endtask

    initial begin
        build_node(32'h100, 32'h200);
        build_node(32'h200, 32'h300);
        build_node(32'h300, 32'h0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        test_reset();
        test_list3();
        test_empty();
        test_backpressure();
        test_abort();
        test_limit();
        test_misaligned_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
